udiv64_host: RTL and testbench

Hardware initiator for the chunked 32-bit GPIO register protocol of the unsigned 64-bit divider `udiv64`. It replaces the MicroBlaze GPIO writes and reads with a fixed sequencer. It accepts a 64-bit dividend/divisor pair over a valid/ready handshake, loads the operands chunk by chunk, and starts the divider. It then polls the state register, gathers the four result chunks, clears the divider, and returns quotient and remainder over a second valid/ready handshake.

---
 rtl/udiv64_pkg.sv | 50 +++++
 rtl/udiv64_host.sv | 154 +++++++++++++++
 tb/tb_udiv64_host.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udiv64_pkg.sv
// udiv64_pkg: register-protocol constants and types shared by udiv64 and its host.
package udiv64_pkg;

   // Chunk indices written through in_loc[1:0]
   localparam logic [1:0] IDX_DVD_LO = 2'd0;
   localparam logic [1:0] IDX_DVD_HI = 2'd1;
   localparam logic [1:0] IDX_DVS_LO = 2'd2;
   localparam logic [1:0] IDX_DVS_HI = 2'd3;

   // Chunk indices read back through out_loc[1:0]
   localparam logic [1:0] IDX_Q_LO = 2'd0;
   localparam logic [1:0] IDX_Q_HI = 2'd1;
   localparam logic [1:0] IDX_R_LO = 2'd2;
   localparam logic [1:0] IDX_R_HI = 2'd3;

   // ctrl_reg bit positions
   localparam int CTRL_START = 0;
   localparam int CTRL_CLEAR = 1;

   // state_reg bit positions
   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_DZ   = 2;

   // in_loc write strobe
   localparam int LOC_WR = 31;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      COLLECT,
      CLEAR,
      RESP
   } state_t;

   // Operand chunk that belongs to a given in_loc index
   function automatic logic [31:0] in_chunk(input logic [1:0]  idx,
                                            input logic [63:0] dvd,
                                            input logic [63:0] dvs);
      case (idx)
         IDX_DVD_LO: return dvd[31:0];
         IDX_DVD_HI: return dvd[63:32];
         IDX_DVS_LO: return dvs[31:0];
         default:    return dvs[63:32];
      endcase
   endfunction

endpackage

// File: rtl/udiv64_host.sv
// udiv64_host: fixed sequencer that loads operands into udiv64, starts it,
// polls for completion, gathers the four result chunks and clears it.
module udiv64_host
   import udiv64_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] dividend,
   input  logic [63:0] divisor,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] quotient,
   output logic [63:0] remainder,
   output logic [1:0]  res_err,
   output logic [31:0] in_loc,
   output logic [31:0] in_val,
   output logic [31:0] ctrl_reg,
   input  logic [31:0] out_loc,
   input  logic [31:0] out_val,
   input  logic [31:0] state_reg
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state, next_state;
   logic [63:0]      dvd_q, dvs_q;
   logic [63:0]      dvd_n, dvs_n;
   logic [3:0]       mask;
   logic [3:0]       mask_cap;
   logic [CNT_W-1:0] tmo_cnt;
   logic [31:0]      in_loc_d, in_val_d, ctrl_d;
   logic [1:0]       load_idx_d;
   logic             accept, busy, done, timed, timeout, capture;
   logic             unused_bits;

   assign req_ready = (state == IDLE);
   assign res_valid = (state == RESP);
   assign accept    = req_valid && req_ready;
   assign busy      = state_reg[ST_BUSY];
   assign done      = state_reg[ST_DONE];
   assign timed     = state inside {START, WAIT, COLLECT};
   assign timeout   = timed && (tmo_cnt == CNT_LAST);
   assign capture   = (state == COLLECT) && done;
   assign mask_cap  = mask | (4'b0001 << out_loc[1:0]);

   assign unused_bits = ^{out_loc[31:2], state_reg[31:3]};

   // State register; reset aborts any operation and returns to IDLE
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process evaluation order.
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state selection; the timeout overrides every wait condition
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = LOAD;
         LOAD:    if (in_loc[1:0] == IDX_DVS_HI) next_state = START;
         START:   if (timeout) next_state = CLEAR;
                  else if (busy || done) next_state = WAIT;
         WAIT:    if (timeout) next_state = CLEAR;
                  else if (done) next_state = COLLECT;
         COLLECT: if (timeout) next_state = CLEAR;
                  else if (capture && (mask_cap == 4'hF)) next_state = CLEAR;
         CLEAR:   if (!done) next_state = RESP;
         RESP:    if (res_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Divider-side output values for the coming state; registered below so the
   // divider only ever sees flop outputs
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      in_loc_d   = '0;
      in_val_d   = '0;
      ctrl_d     = '0;
      dvd_n      = accept ? dividend : dvd_q;
      dvs_n      = accept ? divisor  : dvs_q;
      // The strobe index currently on in_loc doubles as the LOAD step counter
      load_idx_d = (state == LOAD) ? in_loc[1:0] + 2'd1 : IDX_DVD_LO;
      case (next_state)
         LOAD: begin
            in_loc_d[LOC_WR] = 1'b1;
            in_loc_d[1:0]    = load_idx_d;
            in_val_d         = in_chunk(load_idx_d, dvd_n, dvs_n);
         end
         START:   ctrl_d[CTRL_START] = 1'b1;
         CLEAR:   ctrl_d[CTRL_CLEAR] = 1'b1;
         default: ;
      endcase
   end

   // Operand latch, divider-side output flops, timeout counter and result capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_loc    <= '0;
         in_val    <= '0;
         ctrl_reg  <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         quotient  <= '0;
         remainder <= '0;
         res_err   <= '0;
         mask      <= '0;
         tmo_cnt   <= '0;
      end else begin
         in_loc   <= in_loc_d;
         in_val   <= in_val_d;
         ctrl_reg <= ctrl_d;

         // Results start at zero so chunks never delivered read back as 0
         if (accept) begin
            dvd_q     <= dividend;
            dvs_q     <= divisor;
            quotient  <= '0;
            remainder <= '0;
            res_err   <= '0;
            mask      <= '0;
         end

         if ((state != START) && (next_state == START)) tmo_cnt <= '0;
         else if (timed)                                 tmo_cnt <= tmo_cnt + CNT_W'(1);

         if ((state == WAIT) && (next_state == COLLECT)) begin
            res_err[0] <= state_reg[ST_DZ];
            mask       <= '0;
         end

         // Repeated indices simply overwrite their slot
         if (capture) begin
            mask <= mask_cap;
            case (out_loc[1:0])
               IDX_Q_LO: quotient[31:0]   <= out_val;
               IDX_Q_HI: quotient[63:32]  <= out_val;
               IDX_R_LO: remainder[31:0]  <= out_val;
               default:  remainder[63:32] <= out_val;
            endcase
         end

         if (timeout) res_err[1] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_udiv64_host.sv
// tb_udiv64_host: behavioural udiv64 model, randomized requests and a
// queue-based scoreboard checked by an independent result monitor.
module tb_udiv64_host;

   localparam int TMO = 16;

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      logic [1:0]  err;
      int          stall;
   } exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] loc;
      logic [31:0] val;
   } strobe_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] dividend, divisor;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] quotient, remainder;
   logic [1:0]  res_err;
   logic [31:0] in_loc, in_val, ctrl_reg;
   logic [31:0] out_loc, out_val, state_reg;

   udiv64_host #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .reset     (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .res_err   (res_err),
      .in_loc    (in_loc),
      .in_val    (in_val),
      .ctrl_reg  (ctrl_reg),
      .out_loc   (out_loc),
      .out_val   (out_val),
      .state_reg (state_reg)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain unsigned division; the divider model reports q=all-ones, r=dividend on /0
   function automatic exp_t ref_div(input logic [63:0] a, input logic [63:0] b, input int stall);
      exp_t e;
      if (b == 64'd0) begin
         e.q = '1; e.r = a; e.err = 2'b01;
      end else begin
         e.q = a / b; e.r = a % b; e.err = 2'b00;
      end
      e.stall = stall;
      return e;
   endfunction

   // ---------------- behavioural udiv64 model ----------------
   int          lat_cfg    = 3;
   int          ack_delay  = 0;
   int          clr_lat    = 2;
   bit          never_done = 1'b0;
   int          order[$]   = '{0, 1, 2, 3};
   logic [31:0] m_in[4];
   logic [31:0] m_out[4];
   bit          m_busy, m_done, m_dz;
   int          m_cnt, d_cnt;
   int          start_seen, clear_seen, done_at_clear;
   strobe_t     strobes[$];

   always @(negedge clk) begin
      logic [63:0] a, b, q, r;
      int          idx;
      if (rst) begin
         m_busy = 0; m_done = 0; m_dz = 0;
         state_reg = '0; out_loc = '0; out_val = '0;
      end else begin
         if (in_loc[31]) begin
            if (in_loc[1:0] == 2'd0) begin
               strobes.delete();
               start_seen = 0; clear_seen = 0; done_at_clear = -1;
            end
            m_in[in_loc[1:0]] = in_val;
            strobes.push_back('{cyc, in_loc, in_val});
         end
         if (ctrl_reg[1]) begin
            m_busy = 0;
            clear_seen++;
            if (clear_seen == 1) done_at_clear = d_cnt;
            if (clear_seen >= clr_lat) begin m_done = 0; m_dz = 0; end
         end else if (ctrl_reg[0] && !m_busy && !m_done) begin
            start_seen++;
            if (start_seen > ack_delay) begin m_busy = 1; m_cnt = lat_cfg; end
         end else if (m_busy && !never_done) begin
            m_cnt--;
            if (m_cnt <= 0) begin
               a = {m_in[1], m_in[0]};
               b = {m_in[3], m_in[2]};
               if (b == 64'd0) begin q = '1; r = a; m_dz = 1; end
               else begin q = a / b; r = a % b; m_dz = 0; end
               m_out[0] = q[31:0]; m_out[1] = q[63:32];
               m_out[2] = r[31:0]; m_out[3] = r[63:32];
               m_busy = 0; m_done = 1; d_cnt = 0;
            end
         end
         // First order entry is shown twice: once while the host still polls done
         if (m_done) begin
            idx = order[(d_cnt == 0) ? 0 : (d_cnt - 1) % order.size()];
            out_loc = 32'(idx);
            out_val = m_out[idx];
            d_cnt++;
         end else begin
            out_loc = '0; out_val = '0;
         end
         state_reg = {29'd0, m_dz, m_done, m_busy};
      end
   end

   // ---------------- result monitor ----------------
   initial begin
      exp_t        e;
      logic [63:0] sq, sr;
      logic [1:0]  se;
      bit          stable;
      res_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (res_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 64'(res_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               check("quotient", quotient, e.q);
               check("remainder", remainder, e.r);
               check("res_err", 64'(res_err), 64'(e.err));
               sq = quotient; sr = remainder; se = res_err; stable = 1;
               repeat (e.stall) begin
                  @(negedge clk);
                  if (quotient !== sq || remainder !== sr || res_err !== se ||
                      res_valid !== 1'b1 || req_ready !== 1'b0) stable = 0;
               end
               if (e.stall > 0) check("resp_hold_stable", 64'(stable), 64'd1);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   int acc_cyc;

   task automatic send(input logic [63:0] a, input logic [63:0] b, input bit track, input int stall);
      int n = 0;
      while (!req_ready && n < 500) begin @(negedge clk); n++; end
      if (!req_ready) check("req_ready_wait", 64'(req_ready), 64'd1);
      if (track) sb.push_back(ref_div(a, b, stall));
      dividend  = a;
      divisor   = b;
      req_valid = 1'b1;
      @(negedge clk);
      acc_cyc   = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!req_ready && n < 500) begin @(negedge clk); n++; end
      if (!req_ready) check("idle_wait", 64'(req_ready), 64'd1);
   endtask

   logic [31:0] ev[4] = '{32'd100, 32'd0, 32'd7, 32'd0};

   initial begin
      int t0, n;
      logic [63:0] a, b;
      rst = 1'b1; req_valid = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_quotient", quotient, 64'd0);
      check("rst_remainder", remainder, 64'd0);
      check("rst_res_err", 64'(res_err), 64'd0);
      check("rst_in_loc", 64'(in_loc), 64'd0);
      check("rst_in_val", 64'(in_val), 64'd0);
      check("rst_ctrl_reg", 64'(ctrl_reg), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // 100 / 7 with a divider that acknowledges start late
      ack_delay = 2;
      send(64'd100, 64'd7, 1, 1);
      wait_idle();
      ack_delay = 0;
      check("load_strobe_count", 64'(strobes.size()), 64'd4);
      if (strobes.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("load_in_loc", 64'(strobes[i].loc), 64'(32'h8000_0000 | i));
            check("load_in_val", 64'(strobes[i].val), 64'(ev[i]));
            check("load_cycle", 64'(strobes[i].cyc), 64'(acc_cyc + i));
         end
      end
      check("start_held_cycles", 64'(start_seen), 64'(ack_delay + 3));

      // hi/lo chunk mapping
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 1, 0);
      wait_idle();

      // divide by zero with a slow clear acknowledge
      clr_lat = 3;
      send(64'd123, 64'd0, 1, 2);
      wait_idle();
      check("clear_held_cycles", 64'(clear_seen), 64'd3);
      clr_lat = 2;

      // divider never finishes
      never_done = 1'b1;
      send(64'd77, 64'd5, 1, 0);
      sb[sb.size() - 1] = '{64'd0, 64'd0, 2'b10, 0};
      n = 0;
      while (!ctrl_reg[0] && n < 100) begin @(negedge clk); n++; end
      t0 = cyc;
      n = 0;
      while (!res_err[1] && n < 100) begin @(negedge clk); n++; end
      check("timeout_latency", 64'(cyc - t0), 64'(TMO));
      wait_idle();
      never_done = 1'b0;

      // out-of-order, repeated result chunks and a stalled consumer
      order = '{3, 1, 1, 0, 2};
      send({$urandom, $urandom}, {16'd0, 16'($urandom), $urandom}, 1, 5);
      wait_idle();
      check("collect_exit_point", 64'(done_at_clear), 64'd6);
      check("collect_clear_cycles", 64'(clear_seen), 64'(clr_lat));
      order = '{0, 1, 2, 3};

      // reset while waiting for the divider
      lat_cfg = 8;
      send(64'd1000, 64'd3, 0, 0);
      n = 0;
      while (!state_reg[0] && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_wait_ctrl_reg", 64'(ctrl_reg), 64'd0);
      check("rst_wait_res_valid", 64'(res_valid), 64'd0);
      check("rst_wait_req_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      lat_cfg = 3;
      send(64'd50, 64'd5, 1, 0);
      wait_idle();

      // randomized traffic
      for (int i = 0; i < 20; i++) begin
         a = {$urandom, $urandom};
         case ($urandom_range(0, 2))
            0:       b = {32'd0, $urandom};
            1:       b = {$urandom, $urandom};
            default: b = 64'($urandom_range(1, 255));
         endcase
         if (b == 64'd0) b = 64'd1;
         lat_cfg = $urandom_range(1, 4);
         send(a, b, 1, $urandom_range(0, 2));
         wait_idle();
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
